// File: rtl/ros_freq_counter.sv
`default_nettype none
// ============================================================================
//  Module   : ros_freq_counter
//  Purpose  : counts synchronized ring-oscillator rising edges over a gate
//             window of gate_len clk cycles and reports a saturating result.
//  Revision : 1.0
// ============================================================================
module ros_freq_counter #(
  parameter int CNT_WIDTH   = 16,
  parameter int GATE_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ros_in,
  input  logic                  start,
  input  logic [GATE_WIDTH-1:0] gate_len,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  C_CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]  C_CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [GATE_WIDTH-1:0] C_GATE_ONE = GATE_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  state_t                 state_q, state_d;
  logic [GATE_WIDTH-1:0]  gcnt_q, gcnt_d;
  logic [CNT_WIDTH-1:0]   ecnt_q, ecnt_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   ros_s;
  logic                   edge_det;
  logic [CNT_WIDTH-1:0]   ecnt_inc;
  logic                   ovf_inc;

  assign ros_s    = sync_q[SYNC_STAGES-1];
  assign edge_det = ros_s & ~prev_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ros_in};
    prev_d = ros_s;

    // Saturating edge count: once at all-ones the counter holds and flags overflow.
    ecnt_inc = ecnt_q;
    ovf_inc  = ovf_q;
    if (edge_det) begin
      if (ecnt_q == C_CNT_MAX) begin
        ovf_inc = 1'b1;
      end else begin
        ecnt_inc = ecnt_q + C_CNT_ONE;
      end
    end

    state_d    = state_q;
    gcnt_d     = gcnt_q;
    ecnt_d     = ecnt_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          gcnt_d = gate_len;
          ecnt_d = '0;
          ovf_d  = 1'b0;
          busy_d = 1'b1;
          if (gate_len == '0) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            count_d    = '0;
            overflow_d = 1'b0;
          end else begin
            state_d = ST_MEASURE;
          end
        end
      end
      ST_MEASURE: begin
        ecnt_d = ecnt_inc;
        ovf_d  = ovf_inc;
        gcnt_d = gcnt_q - C_GATE_ONE;
        // Last window cycle: publish the count including this cycle's edge.
        if (gcnt_q == C_GATE_ONE) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          count_d    = ecnt_inc;
          overflow_d = ovf_inc;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      state_q    <= ST_IDLE;
      gcnt_q     <= '0;
      ecnt_q     <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      gcnt_q     <= gcnt_d;
      ecnt_q     <= ecnt_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ros_freq_counter.sv
`default_nettype none
// Bench for ros_freq_counter: directed windows and random oscillator patterns
// checked against an edge-counting reference built from the driven ros_in history.
module tb_ros_freq_counter;

  localparam int GW   = 16;
  localparam int SYNC = 2;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          reset;
  logic          ros_in;
  logic          start;
  logic [GW-1:0] gate_len;

  logic          busy16, done16, ovf16;
  logic [15:0]   count16;
  logic          busy4, done4, ovf4;
  logic [3:0]    count4;

  ros_freq_counter #(.CNT_WIDTH(16), .GATE_WIDTH(GW), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .ros_in(ros_in), .start(start), .gate_len(gate_len),
    .busy(busy16), .done(done16), .count(count16), .overflow(ovf16)
  );

  ros_freq_counter #(.CNT_WIDTH(4), .GATE_WIDTH(GW), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .reset(reset), .ros_in(ros_in), .start(start), .gate_len(gate_len),
    .busy(busy4), .done(done4), .count(count4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit ros_hist [MAXC];
  bit rst_hist [MAXC];
  int ros_mode  = 0;
  int ros_half  = 2;
  int ros_phase = 0;
  int exp_cnt16 = 0;
  int exp_cnt4  = 0;
  bit exp_ovf16 = 1'b0;
  bit exp_ovf4  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: record reset seen at this edge, then drive ros_in for the new cycle.
  task automatic step();
    @(posedge clk);
    cyc++;
    rst_hist[cyc] = reset;
    #1;
    case (ros_mode)
      0: ros_in = 1'b0;
      1: begin
        ros_phase++;
        if (ros_phase >= ros_half) begin
          ros_phase = 0;
          ros_in    = ~ros_in;
        end
      end
      default: ros_in = 1'($urandom_range(0, 1));
    endcase
    ros_hist[cyc] = ros_in;
  endtask

  // Synchronized oscillator level seen by the counter during cycle n.
  function automatic bit s_at(input int n);
    for (int k = n - SYNC + 1; k <= n; k++)
      if (k >= 0 && rst_hist[k]) return 1'b0;
    if (n - SYNC < 0) return 1'b0;
    return ros_hist[n - SYNC];
  endfunction

  function automatic int edges_between(input int first, input int last);
    int e = 0;
    for (int n = first; n <= last; n++)
      if (s_at(n) && !s_at(n - 1)) e++;
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ":count16"}, 32'(count16), 32'(exp_cnt16));
    check({tag, ":ovf16"},   32'(ovf16),   32'(exp_ovf16));
    check({tag, ":count4"},  32'(count4),  32'(exp_cnt4));
    check({tag, ":ovf4"},    32'(ovf4),    32'(exp_ovf4));
  endtask

  task automatic window(input int len, input bit hold, input string tag);
    int t0;
    int e;
    start    = 1'b1;
    gate_len = GW'(len);
    t0       = cyc + 1;
    for (int m = t0; m <= t0 + len; m++) begin
      step();
      if (!hold) start = 1'b0;
      gate_len = GW'($urandom);
      check({tag, ":busy16"}, 32'(busy16), 32'd1);
      check({tag, ":busy4"},  32'(busy4),  32'd1);
      if (m == t0 + len) begin
        e         = edges_between(t0, t0 + len - 1);
        exp_cnt16 = (e > 65535) ? 65535 : e;
        exp_ovf16 = (e > 65535);
        exp_cnt4  = (e > 15) ? 15 : e;
        exp_ovf4  = (e > 15);
        check({tag, ":done16"}, 32'(done16), 32'd1);
        check({tag, ":done4"},  32'(done4),  32'd1);
      end else begin
        check({tag, ":done16"}, 32'(done16), 32'd0);
        check({tag, ":done4"},  32'(done4),  32'd0);
      end
      check_outputs(tag);
    end
    step();
    check({tag, ":idle_busy16"}, 32'(busy16), 32'd0);
    check({tag, ":idle_done16"}, 32'(done16), 32'd0);
    check({tag, ":idle_busy4"},  32'(busy4),  32'd0);
    check_outputs({tag, ":idle"});
  endtask

  initial begin
    int len;
    reset    = 1'b1;
    start    = 1'b0;
    gate_len = '0;
    ros_in   = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    check("reset:busy16", 32'(busy16), 32'd0);
    check("reset:done16", 32'(done16), 32'd0);
    check("reset:busy4",  32'(busy4),  32'd0);
    check("reset:done4",  32'(done4),  32'd0);
    check_outputs("reset");

    // Period-4 square wave over 100 cycles.
    ros_mode = 1; ros_half = 2;
    repeat (8) step();
    window(100, 1'b0, "sq100");
    check("sq100:count16_const", 32'(count16), 32'd25);
    check("sq100:ovf16_const",   32'(ovf16),   32'd0);

    // Quiet oscillator: previous result held until the new done.
    ros_mode = 0;
    repeat (4) step();
    window(50, 1'b0, "quiet50");
    check("quiet50:count16_const", 32'(count16), 32'd0);

    // Toggle every clk: 20 edges saturate the 4-bit counter.
    ros_mode = 1; ros_half = 1;
    repeat (6) step();
    window(40, 1'b0, "fast40");
    check("fast40:count16_const", 32'(count16), 32'd20);
    check("fast40:count4_const",  32'(count4),  32'd15);
    check("fast40:ovf4_const",    32'(ovf4),    32'd1);

    window(0, 1'b0, "len0");
    window(1, 1'b0, "len1");

    // start held through a window: exactly one done, next accept one IDLE cycle later.
    ros_mode = 2;
    window(20, 1'b1, "hold20");
    window(20, 1'b0, "after_hold");

    for (int i = 0; i < 6; i++) begin
      ros_mode = int'($urandom_range(1, 2));
      ros_half = int'($urandom_range(1, 5));
      len      = int'($urandom_range(0, 60));
      repeat ($urandom_range(0, 3)) step();
      window(len, 1'b0, "rand");
    end

    // Reset in the middle of a window aborts it with no done.
    ros_mode = 1; ros_half = 2;
    repeat (8) step();
    start    = 1'b1;
    gate_len = GW'(100);
    step();
    start = 1'b0;
    repeat (9) begin
      step();
      check("abort:pre_done16", 32'(done16), 32'd0);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_cnt16 = 0; exp_ovf16 = 1'b0; exp_cnt4 = 0; exp_ovf4 = 1'b0;
    check("abort:busy16", 32'(busy16), 32'd0);
    check("abort:done16", 32'(done16), 32'd0);
    check("abort:busy4",  32'(busy4),  32'd0);
    check_outputs("abort");
    repeat (20) begin
      step();
      check("abort:no_done16", 32'(done16), 32'd0);
      check("abort:no_busy16", 32'(busy16), 32'd0);
    end
    window(100, 1'b0, "post_reset");
    check("post_reset:count16_const", 32'(count16), 32'd25);
    check("post_reset:ovf16_const",   32'(ovf16),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
